// File: rtl/enc_pkg.sv
// ----------------------------------------------------------------------------
// enc_pkg
// Shared constants, state encoding and helpers for the sequential 8-to-3
// encoder (encoder_8to3_seq) and its priority-encoder sub-block.
//   N_IN / N_OUT : request vector width and encoded index width
//   ST_IDLE/SCAN : 1-bit FSM state encoding
//   popcount8    : number of set bits in an 8-bit vector (0..8)
// ----------------------------------------------------------------------------
package enc_pkg;

    localparam int unsigned N_IN  = 8;
    localparam int unsigned N_OUT = 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StScan = ST_SCAN
    } enc_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_enc_8to3.sv
// ----------------------------------------------------------------------------
// prio_enc_8to3
// Purely combinational priority encoder: returns the index of the
// highest-priority set bit of vec_i and flags whether any bit is set.
// Default priority is MSB first; defining ENC_LSB_FIRST_EN selects LSB first.
//   vec_i : request vector
//   idx_o : index of the winning bit (0 when vec_i is empty)
//   any_o : at least one bit of vec_i is set
// ----------------------------------------------------------------------------
module prio_enc_8to3 #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned N_OUT = 3
) (
    input  logic [N_IN-1:0]  vec_i,
    output logic [N_OUT-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
`ifdef ENC_LSB_FIRST_EN
        // Scan downwards so the lowest set bit is written last and wins.
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = N_OUT'(i);
        end
`else
        // Scan upwards so the highest set bit is written last and wins.
        for (int i = 0; i < N_IN; i++) begin
            if (vec_i[i]) idx_o = N_OUT'(i);
        end
`endif
    end

endmodule

// File: rtl/encoder_8to3_seq.sv
// ----------------------------------------------------------------------------
// encoder_8to3_seq
// Sequential 8-to-3 encoder. Accepts a multi-hot request vector in IDLE and
// emits the index of each set bit, one per accepted beat, in priority order
// over a valid/ready handshake. Build option ENC_LSB_FIRST_EN (macro) flips
// the emission order to LSB first; default is MSB first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, IN        : request vector offer
//   in_ready            : block is IDLE and will accept a vector
//   out_valid, out_ready: output handshake
//   OUT                 : current index
//   last                : OUT is the final pending bit of this vector
//   remaining           : number of pending bits (0..8)
//   zero_err            : one-cycle pulse after an empty vector was offered
// ----------------------------------------------------------------------------
module encoder_8to3_seq
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  IN,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] OUT,
    output logic             last,
    output logic [3:0]       remaining,
    output logic             zero_err
);

    enc_state_e        state_q;
    logic [N_IN-1:0]   pending_q;
    logic              zero_err_q;

    logic [N_OUT-1:0]  idx;
    logic              any_set;
    logic [3:0]        cnt;
    logic              last_w;
    logic [N_IN-1:0]   clr_mask;

    prio_enc_8to3 #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_prio (
        .vec_i (pending_q),
        .idx_o (idx),
        .any_o (any_set)
    );

    // Outputs depend only on registered state/pending, never on inputs.
    always_comb begin
        cnt      = popcount8(pending_q);
        last_w   = (state_q == StScan) && (cnt == 4'd1);
        clr_mask = '0;
        clr_mask[idx] = 1'b1;
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StScan);
    assign OUT       = any_set ? idx : '0;
    assign last      = last_w;
    assign remaining = cnt;
    assign zero_err  = zero_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            zero_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (IN != '0) begin
                            pending_q <= IN;
                            state_q   <= StScan;
                        end else begin
                            zero_err_q <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    if (out_ready) begin
                        if (last_w) begin
                            pending_q <= '0;
                            state_q   <= StIdle;
                        end else begin
                            pending_q <= pending_q & ~clr_mask;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    pending_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// ----------------------------------------------------------------------------
// tb_encoder_8to3_seq
// Self-checking bench for encoder_8to3_seq: a table of request vectors with
// hand-computed MSB-first index sequences, plus directed sequences for stall,
// empty-vector and mid-vector asynchronous reset.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_encoder_8to3_seq;

`ifdef ENC_LSB_FIRST_EN
    localparam bit LsbFirst = 1'b1;
`else
    localparam bit LsbFirst = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] IN;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] OUT;
    logic       last;
    logic [3:0] remaining;
    logic       zero_err;

    int total;
    int bad;

    encoder_8to3_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .IN        (IN),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (OUT),
        .last      (last),
        .remaining (remaining),
        .zero_err  (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      vec;
        int              n;
        logic [7:0][2:0] seq;  // seq[k] = k-th index in MSB-first order
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Loads tbl[t] from IDLE with out_ready high and checks every beat.
    task automatic drain(input int t);
        logic [2:0] exp_idx;
        int         n;
        n = tbl[t].n;
        chk("pre_load_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        IN        = tbl[t].vec;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        IN       = 8'h00;
        for (int k = 0; k < n; k++) begin
            exp_idx = LsbFirst ? tbl[t].seq[n-1-k] : tbl[t].seq[k];
            chk("beat_out_valid", out_valid, 1);
            chk("beat_in_ready", in_ready, 0);
            chk("beat_out", OUT, exp_idx);
            chk("beat_remaining", remaining, n - k);
            chk("beat_last", last, (k == n - 1) ? 1 : 0);
            @(negedge clk);
        end
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_remaining", remaining, 0);
        chk("post_last", last, 0);
        chk("post_out", OUT, 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        IN        = 8'h00;
        out_ready = 1'b0;

        tbl[0].vec = 8'b0010_0100; tbl[0].n = 2; tbl[0].seq = '0;
        tbl[0].seq[0] = 3'd5; tbl[0].seq[1] = 3'd2;
        tbl[1].vec = 8'hFF; tbl[1].n = 8; tbl[1].seq = '0;
        for (int k = 0; k < 8; k++) tbl[1].seq[k] = 3'(7 - k);
        tbl[2].vec = 8'h01; tbl[2].n = 1; tbl[2].seq = '0;
        tbl[2].seq[0] = 3'd0;
        tbl[3].vec = 8'hA5; tbl[3].n = 4; tbl[3].seq = '0;
        tbl[3].seq[0] = 3'd7; tbl[3].seq[1] = 3'd5; tbl[3].seq[2] = 3'd2; tbl[3].seq[3] = 3'd0;
        tbl[4].vec = 8'h80; tbl[4].n = 1; tbl[4].seq = '0;
        tbl[4].seq[0] = 3'd7;
        tbl[5].vec = 8'h10; tbl[5].n = 1; tbl[5].seq = '0;
        tbl[5].seq[0] = 3'd4;

        // Reset state, with a load attempted while in reset.
        in_valid = 1'b1;
        IN       = 8'h3C;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", OUT, 0);
        chk("rst_last", last, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_zero_err", zero_err, 0);
        in_valid = 1'b0;
        IN       = 8'h00;
        rst_n    = 1'b1;
        @(negedge clk);

        // Table-driven drains with out_ready tied high.
        for (int t = 0; t < 5; t++) begin
            drain(t);
        end

        // Stall: out_ready low for 3 cycles, second offer must be ignored.
        in_valid  = 1'b1;
        IN        = 8'b1000_0001;
        out_ready = 1'b0;
        @(negedge clk);
        IN = 8'h0F;
        for (int c = 0; c < 3; c++) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out", OUT, LsbFirst ? 0 : 7);
            chk("stall_remaining", remaining, 2);
            chk("stall_last", last, 0);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        IN        = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_b2_out", OUT, LsbFirst ? 7 : 0);
        chk("stall_b2_remaining", remaining, 1);
        chk("stall_b2_last", last, 1);
        @(negedge clk);
        chk("stall_done_out_valid", out_valid, 0);
        chk("stall_done_in_ready", in_ready, 1);
        @(negedge clk);
        chk("stall_no_reload", out_valid, 0);

        // Empty vector: one-cycle zero_err, no state change.
        chk("zero_err_before", zero_err, 0);
        in_valid = 1'b1;
        IN       = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        chk("zero_err_pulse", zero_err, 1);
        chk("zero_out_valid", out_valid, 0);
        chk("zero_in_ready", in_ready, 1);
        @(negedge clk);
        chk("zero_err_cleared", zero_err, 0);
        chk("zero_still_idle", out_valid, 0);

        // Mid-vector asynchronous reset.
        in_valid  = 1'b1;
        IN        = 8'h0F;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        IN       = 8'h00;
        chk("mid_first_out", OUT, LsbFirst ? 0 : 3);
        @(negedge clk);
        out_ready = 1'b0;
        chk("mid_second_remaining", remaining, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_out", OUT, 0);
        chk("async_last", last, 0);
        chk("async_remaining", remaining, 0);
        chk("async_zero_err", zero_err, 0);
        in_valid = 1'b1;
        IN       = 8'h22;
        @(negedge clk);
        chk("in_reset_no_load", out_valid, 0);
        in_valid = 1'b0;
        IN       = 8'h00;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("after_rst_idle", out_valid, 0);
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
